uart_tx_buffered: RTL and testbench

//  8N1 UART transmitter with an internal byte FIFO; the transmit-side counterpart of the UART receive path.
//  The core pushes bytes at clock speed, and the block serialises them onto txd at CLK_PER_BIT clocks/bit.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 109 ++++++++++
 tb/tb_uart_tx_buffered.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding and default bit period.
// Both the transmit and receive paths take their default baud from here.
package uart_pkg;
   localparam int UART_CLK_PER_BIT = 868;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO, count register, first-word-fall-through head on rdata; 1-cycle write-to-count.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   wr_en,
   input  logic [W-1:0]           wdata,
   input  logic                   rd_en,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          push;
   logic          pop;

   // full comes from the pre-edge count, so a same-edge pop never frees room for a push
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;
   assign rdata = mem[rd_ptr];
   assign count = cnt;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter; txd falls one edge after a push into an idle, empty block.
// Backpressure: full asserts at DEPTH queued bytes and further pushes are dropped.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
   parameter int DEPTH       = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [7:0]             wdata,
   input  logic                   wr_en,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   txd
);
   localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

   tx_state_t     state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [7:0]    head;
   logic          fifo_empty;
   logic          bit_end;
   logic          pop;

   assign bit_end = (bit_cnt == LAST);
   assign pop     = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));

   uart_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .wr_en (wr_en),
      .wdata (wdata),
      .rd_en (pop),
      .rdata (head),
      .full  (full),
      .empty (fifo_empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
         busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (!fifo_empty) begin
                  shreg <= head;
                  txd   <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  txd     <= shreg[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  shreg   <= shreg >> 1;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     txd     <= shreg[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  // chain straight into the next start bit when more bytes are waiting
                  if (!fifo_empty) begin
                     shreg <= head;
                     txd   <= 1'b0;
                     state <= START;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLK_PER_BIT=4, DEPTH=4 with a line-side receiver model.
module tb_uart_tx_buffered;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rstn;
   logic [7:0] wdata;
   logic       wr_en;
   logic       full;
   logic [2:0] count;
   logic       busy;
   logic       txd;

   int total = 0;
   int bad   = 0;

   uart_tx_buffered #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .wdata (wdata),
      .wr_en (wr_en),
      .full  (full),
      .count (count),
      .busy  (busy),
      .txd   (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // receiver model: samples mid-bit on negedges, records each byte and its start cycle
   logic [7:0] rxq [$];
   int         rx_t [$];
   int         ncyc = 0;
   int         ferr = 0;
   bit         mon_act = 0;
   int         mon_ph  = 0;
   int         mon_st  = 0;
   logic [7:0] mon_sh;

   always @(negedge clk) begin
      ncyc++;
      if (!rstn) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (txd === 1'b0) begin
            mon_act = 1;
            mon_ph  = 0;
            mon_st  = ncyc;
         end
      end else begin
         mon_ph++;
         if (mon_ph == 2 && txd !== 1'b0) ferr++;
         if (mon_ph >= 6 && mon_ph <= 34 && (mon_ph % 4) == 2)
            mon_sh[(mon_ph - 6) / 4] = txd;
         if (mon_ph == 38) begin
            if (txd === 1'b1) begin
               rxq.push_back(mon_sh);
               rx_t.push_back(mon_st);
            end else begin
               ferr++;
            end
            mon_act = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rx_at(input int i);
      if (i < rxq.size()) return {24'h0, rxq[i]};
      return 32'hDEAD;
   endfunction

   task automatic wait_idle(input int maxc, output int n);
      n = 0;
      while (busy && n < maxc) begin
         n++;
         tick();
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic clear_rx();
      rxq.delete();
      rx_t.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;     // bit s = expected txd during slot s
      int         busy_len;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      logic [3:0] smp;
      int bcnt;
      bit high_ok;

      vecs[0] = '{8'h55, 10'h2AA, 40};
      vecs[1] = '{8'h00, 10'h200, 40};
      vecs[2] = '{8'hFF, 10'h3FE, 40};
      vecs[3] = '{8'h80, 10'h300, 40};
      vecs[4] = '{8'h01, 10'h202, 40};

      rstn  = 1'b0;
      wr_en = 1'b0;
      wdata = 8'h00;
      repeat (3) tick();
      chk("reset_txd", {31'b0, txd}, 32'd1);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_full", {31'b0, full}, 32'd0);
      chk("reset_count", {29'b0, count}, 32'd0);
      rstn = 1'b1;
      repeat (3) tick();

      // single frames from idle, slot-by-slot line check
      for (int v = 0; v < 5; v++) begin
         clear_rx();
         wr_en = 1'b1;
         wdata = vecs[v].data;
         tick();
         wr_en = 1'b0;
         chk("push_count", {29'b0, count}, 32'd1);
         chk("pre_start_txd", {31'b0, txd}, 32'd1);
         chk("pre_start_busy", {31'b0, busy}, 32'd0);
         tick();
         chk("start_latency_txd", {31'b0, txd}, 32'd0);
         bcnt = 0;
         for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < CPB; c++) begin
               smp[c] = txd;
               if (busy) bcnt++;
               tick();
            end
            chk($sformatf("slot%0d_byte%02h", s, vecs[v].data), {28'b0, smp},
                {28'b0, {4{vecs[v].frame[s]}}});
         end
         chk("busy_len", bcnt, vecs[v].busy_len);
         chk("end_busy", {31'b0, busy}, 32'd0);
         chk("end_txd", {31'b0, txd}, 32'd1);
         chk("single_rx_n", rxq.size(), 32'd1);
         chk("single_rx_byte", rx_at(0), {24'h0, vecs[v].data});
         repeat (3) tick();
      end

      // two bytes on consecutive edges: back-to-back frames
      clear_rx();
      wr_en = 1'b1;
      wdata = 8'hA3;
      tick();
      wdata = 8'h0F;
      tick();
      wr_en = 1'b0;
      wait_idle(300, n);
      chk("pair_busy_len", n, 32'd80);
      chk("pair_rx_n", rxq.size(), 32'd2);
      chk("pair_rx0", rx_at(0), 32'hA3);
      chk("pair_rx1", rx_at(1), 32'h0F);
      chk("pair_gap", (rx_t.size() == 2) ? rx_t[1] - rx_t[0] : -1, 32'd40);
      repeat (3) tick();

      // overfill, then a push rejected on the same edge as a pop
      clear_rx();
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1;
         wdata = 8'(i + 1);
         tick();
         if (i == 4) begin
            chk("fill_count", {29'b0, count}, 32'd4);
            chk("fill_full", {31'b0, full}, 32'd1);
         end
      end
      wr_en = 1'b0;
      chk("drop_count", {29'b0, count}, 32'd4);
      chk("drop_full", {31'b0, full}, 32'd1);
      repeat (35) tick();
      chk("prepop_count", {29'b0, count}, 32'd4);
      wr_en = 1'b1;
      wdata = 8'h77;
      tick();
      wr_en = 1'b0;
      chk("popedge_count", {29'b0, count}, 32'd3);
      chk("popedge_full", {31'b0, full}, 32'd0);
      chk("popedge_txd", {31'b0, txd}, 32'd0);
      wait_idle(600, n);
      chk("full_rx_n", rxq.size(), 32'd5);
      for (int i = 0; i < 5; i++) chk("full_rx_byte", rx_at(i), 32'(i + 1));

      // push coinciding with the STOP-end pop while partially filled
      clear_rx();
      repeat (3) tick();
      wr_en = 1'b1; wdata = 8'h11; tick();
      wdata = 8'h22; tick();
      wdata = 8'h44; tick();
      wr_en = 1'b0;
      repeat (38) tick();
      chk("mid_prepop_count", {29'b0, count}, 32'd2);
      wr_en = 1'b1;
      wdata = 8'h33;
      tick();
      wr_en = 1'b0;
      chk("mid_pushpop_count", {29'b0, count}, 32'd2);
      wait_idle(600, n);
      chk("mid_rx_n", rxq.size(), 32'd4);
      chk("mid_rx0", rx_at(0), 32'h11);
      chk("mid_rx1", rx_at(1), 32'h22);
      chk("mid_rx2", rx_at(2), 32'h44);
      chk("mid_rx3", rx_at(3), 32'h33);

      // reset in the middle of a data bit with bytes queued
      clear_rx();
      repeat (3) tick();
      wr_en = 1'b1; wdata = 8'hC4; tick();
      wdata = 8'h5A; tick();
      wdata = 8'h3C; tick();
      wr_en = 1'b0;
      repeat (13) tick();
      chk("abort_pre_count", {29'b0, count}, 32'd2);
      chk("abort_pre_busy", {31'b0, busy}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("abort_txd", {31'b0, txd}, 32'd1);
      chk("abort_count", {29'b0, count}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_full", {31'b0, full}, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      high_ok = 1;
      for (int i = 0; i < 60; i++) begin
         if (txd !== 1'b1 || busy !== 1'b0) high_ok = 0;
         tick();
      end
      chk("abort_line_idle", {31'b0, high_ok}, 32'd1);
      chk("abort_rx_n", rxq.size(), 32'd0);
      wr_en = 1'b1;
      wdata = 8'h96;
      tick();
      wr_en = 1'b0;
      tick();
      wait_idle(100, n);
      chk("recover_rx_n", rxq.size(), 32'd1);
      chk("recover_rx0", rx_at(0), 32'h96);
      chk("framing_errors", ferr, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
